// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// State encoding is fixed so it can be decoded in the debug tooling.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the arbiter (master) and the bus devices (slave).
interface bus_arbiter_if #(
  parameter int NUM_DEV = 4
) ();
  localparam int SEL_W = $clog2(NUM_DEV);

  logic [NUM_DEV-1:0] req;
  logic [NUM_DEV-1:0] grant;
  logic [SEL_W-1:0]   bus_sel;
  logic               bus_busy;
  logic               turnaround;
  logic               timeout;

  modport master (
    input  req,
    output grant,
    output bus_sel,
    output bus_busy,
    output turnaround,
    output timeout
  );

  modport slave (
    output req,
    input  grant,
    input  bus_sel,
    input  bus_busy,
    input  turnaround,
    input  timeout
  );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin winner search starting one past the last owner.
module rr_picker #(
  parameter int NUM_DEV = 4,
  localparam int SEL_W = $clog2(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [SEL_W-1:0]   last_owner,
  output logic [SEL_W-1:0]   win_idx,
  output logic               any_req
);

  logic [SEL_W-1:0]   cand_idx [NUM_DEV];
  logic [NUM_DEV-1:0] cand_req;

  // Candidate gi is (last_owner + 1 + gi) mod NUM_DEV; the sum is < 2*NUM_DEV,
  // so one conditional subtract replaces a general modulo.
  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_cand
      logic [SEL_W:0] sum;
      assign sum = {1'b0, last_owner} + (SEL_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (SEL_W+1)'(NUM_DEV))
                            ? SEL_W'(sum - (SEL_W+1)'(NUM_DEV))
                            : sum[SEL_W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_idx = cand_idx[0];
    any_req = |req;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a dead turnaround cycle between owners.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles when others wait.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_DEV  = 4,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam int SEL_W = $clog2(NUM_DEV);

  generate
    if (NUM_DEV < 2 || MAX_HOLD < 1) begin : g_bad_param
      $error("bus_arbiter: NUM_DEV must be >= 2 and MAX_HOLD >= 1");
    end
  endgenerate

  arb_state_t         state_reg, state_next;
  logic [NUM_DEV-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [SEL_W-1:0]   last_owner_reg, last_owner_next;
  logic               busy_reg, busy_next;
  logic               turn_reg, turn_next;
  logic               timeout_reg, timeout_next;

  logic [SEL_W-1:0]   win_idx;
  logic               any_req;
  logic               owner_req;
  logic               force_release;

  rr_picker #(
    .NUM_DEV (NUM_DEV)
  ) u_picker (
    .req        (bus.req),
    .last_owner (last_owner_reg),
    .win_idx    (win_idx),
    .any_req    (any_req)
  );

  assign owner_req = bus.req[last_owner_reg];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              others_req;
  logic              hold_expired;

  assign others_req    = |(bus.req & ~grant_reg);
  assign hold_expired  = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign force_release = (state_reg == GRANT) && hold_expired && others_req;

  // Counter restarts on every GRANT entry and saturates while nobody else waits.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (state_reg != GRANT || state_next != GRANT) begin
      hold_cnt_next = '0;
    end else if (!hold_expired) begin
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`else
  assign force_release = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    sel_next        = sel_reg;
    last_owner_next = last_owner_reg;
    busy_next       = busy_reg;
    turn_next       = 1'b0;
    timeout_next    = 1'b0;

    case (state_reg)
      IDLE, TURN: begin
        if (any_req) begin
          state_next      = GRANT;
          grant_next      = {{(NUM_DEV-1){1'b0}}, 1'b1} << win_idx;
          sel_next        = win_idx;
          last_owner_next = win_idx;
          busy_next       = 1'b1;
        end else begin
          state_next = IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
        end
      end
      GRANT: begin
        // Only a voluntary drop or the hold limit ends ownership.
        if (!owner_req || force_release) begin
          state_next   = TURN;
          grant_next   = '0;
          busy_next    = 1'b0;
          turn_next    = 1'b1;
          timeout_next = force_release && owner_req;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      sel_reg        <= '0;
      last_owner_reg <= SEL_W'(NUM_DEV - 1);
      busy_reg       <= 1'b0;
      turn_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      sel_reg        <= sel_next;
      last_owner_reg <= last_owner_next;
      busy_reg       <= busy_next;
      turn_reg       <= turn_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign bus.grant      = grant_reg;
  assign bus.bus_sel    = sel_reg;
  assign bus.bus_busy   = busy_reg;
  assign bus.turnaround = turn_reg;
  assign bus.timeout    = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NUM_DEV=4, MAX_HOLD=4).
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if #(.NUM_DEV(4)) bus ();

  bus_arbiter #(
    .NUM_DEV  (4),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Packed view: {grant[3:0], bus_sel[1:0], bus_busy, turnaround, timeout}
  function automatic logic [8:0] obs();
    return {bus.grant, bus.bus_sel, bus.bus_busy, bus.turnaround, bus.timeout};
  endfunction

  function automatic logic [8:0] ex(logic [3:0] g, int s, logic b, logic t, logic o);
    return {g, 2'(s), b, t, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst     = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = obs();
      checks++;
      $display("reset      cyc%0d state=%b", c, got);
      if (got !== ex(4'b0000, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_hold got=%b want=%b", got, ex(4'b0000, 0, 0, 0, 0));
      end
    end
    rst = 1'b0;
    tick();
    got = obs();
    checks++;
    $display("reset      release state=%b", got);
    if (got !== ex(4'b0001, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL reset_first_grant got=%b want=%b", got, ex(4'b0001, 0, 1, 0, 0));
    end
  endtask

  task automatic test_single();
    logic [3:0] req_tab [7];
    logic [8:0] exp_tab [7];
    logic [8:0] got;
    req_tab = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    exp_tab = '{ex(4'b0100, 2, 1, 0, 0), ex(4'b0100, 2, 1, 0, 0), ex(4'b0100, 2, 1, 0, 0),
                ex(4'b0100, 2, 1, 0, 0), ex(4'b0100, 2, 1, 0, 0),
                ex(4'b0000, 2, 0, 1, 0), ex(4'b0000, 2, 0, 0, 0)};
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      bus.req = req_tab[k];
      tick();
      got = obs();
      checks++;
      $display("single     step%0d req=%b state=%b", k, req_tab[k], got);
      if (got !== exp_tab[k]) begin
        errors++;
        $display("FAIL single_step%0d got=%b want=%b", k, got, exp_tab[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [8:0] got;
    logic [8:0] want;
    int         nxt;
    apply_reset();
    bus.req = 4'b1111;
    tick();
    got = obs();
    checks++;
    $display("fairness   first state=%b", got);
    if (got !== ex(4'b0001, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL fair_first got=%b want=%b", got, ex(4'b0001, 0, 1, 0, 0));
    end
    for (int o = 0; o < 4; o++) begin
      nxt = (o + 1) % 4;
      tick();
      got  = obs();
      want = ex(4'(1 << o), o, 1, 0, 0);
      checks++;
      $display("fairness   own%0d hold state=%b", o, got);
      if (got !== want) begin
        errors++;
        $display("FAIL fair_hold%0d got=%b want=%b", o, got, want);
      end
      bus.req = 4'b1111 & ~4'(1 << o);
      tick();
      got  = obs();
      want = ex(4'b0000, o, 0, 1, 0);
      checks++;
      $display("fairness   own%0d turn state=%b", o, got);
      if (got !== want) begin
        errors++;
        $display("FAIL fair_turn%0d got=%b want=%b", o, got, want);
      end
      bus.req = 4'b1111;
      tick();
      got  = obs();
      want = ex(4'(1 << nxt), nxt, 1, 0, 0);
      checks++;
      $display("fairness   next%0d state=%b", nxt, got);
      if (got !== want) begin
        errors++;
        $display("FAIL fair_next%0d got=%b want=%b", o, got, want);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] req_tab [7];
    logic [8:0] exp_tab [7];
    logic [8:0] got;
    req_tab = '{4'b1000, 4'b0000, 4'b1010, 4'b1000, 4'b1010, 4'b0010, 4'b1010};
    exp_tab = '{ex(4'b1000, 3, 1, 0, 0), ex(4'b0000, 3, 0, 1, 0), ex(4'b0010, 1, 1, 0, 0),
                ex(4'b0000, 1, 0, 1, 0), ex(4'b1000, 3, 1, 0, 0),
                ex(4'b0000, 3, 0, 1, 0), ex(4'b0010, 1, 1, 0, 0)};
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      bus.req = req_tab[k];
      tick();
      got = obs();
      checks++;
      $display("wrap       step%0d req=%b state=%b", k, req_tab[k], got);
      if (got !== exp_tab[k]) begin
        errors++;
        $display("FAIL wrap_step%0d got=%b want=%b", k, got, exp_tab[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] got;
    apply_reset();
    bus.req = 4'b0100;
    tick();
    got = obs();
    checks++;
    $display("midreset   grant state=%b", got);
    if (got !== ex(4'b0100, 2, 1, 0, 0)) begin
      errors++;
      $display("FAIL midrst_grant got=%b want=%b", got, ex(4'b0100, 2, 1, 0, 0));
    end
    rst = 1'b1;
    tick();
    got = obs();
    checks++;
    $display("midreset   reset state=%b", got);
    if (got !== ex(4'b0000, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL midrst_drop got=%b want=%b", got, ex(4'b0000, 0, 0, 0, 0));
    end
    rst = 1'b0;
    tick();
    got = obs();
    checks++;
    $display("midreset   regrant state=%b", got);
    if (got !== ex(4'b0100, 2, 1, 0, 0)) begin
      errors++;
      $display("FAIL midrst_regrant got=%b want=%b", got, ex(4'b0100, 2, 1, 0, 0));
    end
  endtask

  task automatic test_timeout();
    logic [8:0] got;
    logic [8:0] want;
    apply_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      got = obs();
      if (c < 4)       want = ex(4'b0001, 0, 1, 0, 0);
      else if (c == 4) want = ex(4'b0000, 0, 0, 1, 1);
      else             want = ex(4'b0010, 1, 1, 0, 0);
      checks++;
      $display("timeout    cyc%0d state=%b", c, got);
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_cyc%0d got=%b want=%b", c, got, want);
      end
    end
    apply_reset();
    bus.req = 4'b0001;
`endif
    // Without contention (or without the feature) device 0 keeps the bus.
    for (int c = 0; c < 10; c++) begin
      tick();
      got = obs();
      checks++;
      $display("hold       cyc%0d state=%b", c, got);
      if (got !== ex(4'b0001, 0, 1, 0, 0)) begin
        errors++;
        $display("FAIL hold_cyc%0d got=%b want=%b", c, got, ex(4'b0001, 0, 1, 0, 0));
      end
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_mid_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequencing controller for the team's shared N-bit mux-driven bus.
- Takes level requests from NUM_DEV devices and grants the bus to one owner at a time, round-robin.
- Drives the mux select and a one-hot grant vector.
- Inserts one dead turnaround cycle between owners so the gate-level mux settles before the next driver's data is sampled.

Parameters:
- NUM_DEV, 4, number of requesting devices (>=2).
- SEL_W, $clog2(NUM_DEV), width of the mux select; derived, not overridden.
- MAX_HOLD, 8, maximum consecutive owned cycles when ARB_TIMEOUT_EN is defined (>=1).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_DEV  per-device level request; held high while the device wants or keeps the bus.
- grant  output  NUM_DEV  one-hot registered grant; all-zero when no owner.
- bus_sel  output  SEL_W  registered mux select (index of current or last owner).
- bus_busy  output  1  high while in GRANT state.
- turnaround  output  1  high during the dead cycle between owners.
- timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- States are IDLE, GRANT and TURN. All outputs are registered.
- Reset values:
  - state=IDLE, grant=0, bus_sel=0, bus_busy=0, turnaround=0, timeout=0.
  - last_owner=NUM_DEV-1, so device 0 wins the first arbitration.
  - hold_cnt=0.
- Reset dominates every other event. A reset mid-GRANT drops grant on the next edge.
- Round-robin pick:
  - Search req starting at index (last_owner+1) mod NUM_DEV, wrapping. The first set bit wins.
  - The pick is combinational. The winner is registered into grant, bus_sel and last_owner.
- IDLE:
  - If req != 0: go to GRANT next edge with the winner.
  - Grant latency is 1 cycle from req high to grant high.
  - Otherwise stay in IDLE.
- GRANT:
  - grant[owner]=1, bus_busy=1.
  - If req[owner] is 0 at an edge: go to TURN, grant=0, bus_busy=0, turnaround=1.
  - Requests from other devices never preempt the owner, except via the timeout.
- TURN:
  - Lasts exactly 1 cycle.
  - bus_sel holds the previous owner (no select glitch while the bus is undriven by a grant).
  - At the next edge: if req != 0, go to GRANT with the round-robin winner from last_owner+1. Otherwise go to IDLE.
  - The previous owner may re-win only if no other device requests.
- bus_sel changes only on entry to GRANT. In IDLE and TURN it holds the last owner.
- Simultaneous requests: resolved purely by the round-robin order.
- A request dropped during TURN before it is granted is ignored. There is no latching of requests.
- Invariant: grant is one-hot or zero. When grant != 0, grant[bus_sel]=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - hold_cnt increments each GRANT cycle.
  - When hold_cnt==MAX_HOLD-1 and some other device requests: force TURN at that edge, pulse timeout=1 for the TURN cycle, clear hold_cnt.
  - If no other device requests, the owner keeps the bus and hold_cnt saturates at MAX_HOLD-1.
  - hold_cnt clears on every GRANT entry.
- When undefined: no hold_cnt logic, timeout is tied 0, and the owner holds the bus indefinitely.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2);
  - the default MAX_HOLD constant.
- Sub-module rr_picker: combinational. Inputs req and last_owner; outputs win_idx and any_req. Parameterized by NUM_DEV.

Test Plan:
All scenarios use NUM_DEV=4 and MAX_HOLD=4 unless noted.
- Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, bus_sel=0, and all flags 0 throughout. After rst falls, grant=4'b0001 one cycle later.
- Single requester: req=4'b0100 held 5 cycles, then dropped -> grant=4'b0100 from cycle+1 with bus_sel=2 and bus_busy=1. After the drop: one turnaround=1 cycle with bus_sel still 2, then IDLE.
- Round-robin fairness: req=4'b1111 with each owner dropping req for 1 cycle after 2 owned cycles -> grant order 0,1,2,3,0, with exactly one TURN cycle between each.
- Wrap and skip: last_owner=3, req=4'b1010 -> grant=4'b0010, then 4'b1000, then 4'b0010.
- Mid-operation reset: rst asserted during GRANT of device 2 -> next edge grant=0 and bus_sel=0. After release with req=4'b0100, device 2 is granted (last_owner was reset to 3).
- ARB_TIMEOUT_EN: device 0 holds req, device 1 requests at cycle 1 -> device 0 is forced off after 4 GRANT cycles with timeout=1 during TURN, then grant=4'b0010. Same run with only device 0 requesting -> no timeout.
